lap_stopwatch: RTL and testbench
================================

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameter CLK_DIV SHALL be declared: default 500000; clock cycles per centisecond tick; minimum 2.
REQ-003 Parameter LAP_DEPTH SHALL be declared: default 4; lap-memory entries; range 1..16.
REQ-004 Port clock SHALL be an input, 1 bit: system clock.
REQ-005 Port reset_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-006 Port start_stop SHALL be an input, 1 bit: single-cycle pulse; toggles run/pause.
REQ-007 Port clear SHALL be an input, 1 bit: single-cycle pulse; returns to IDLE.
REQ-008 Port lap SHALL be an input, 1 bit: single-cycle pulse; captures the current time.
REQ-009 Port mode SHALL be an input, 1 bit: 0 = count up, 1 = count down; sampled only in IDLE.
REQ-010 Port preset SHALL be an input, 24 bits: BCD mm:ss:cc countdown start value; sampled on the IDLE->RUN transition.
REQ-011 Port lap_sel SHALL be an input, $clog2(LAP_DEPTH) bits: index of the lap entry to read.
REQ-012 Port view_lap SHALL be an input, 1 bit: 1 selects a lap entry on disp_bcd.
REQ-013 Port disp_bcd SHALL be an output, 24 bits: six BCD digits, mm:ss:cc, with cc in [7:0].
REQ-014 Port running SHALL be an output, 1 bit: high in state RUN.
REQ-015 Port lap_count SHALL be an output, $clog2(LAP_DEPTH+1) bits: number of stored laps.
REQ-016 Port lap_full SHALL be an output, 1 bit: lap_count == LAP_DEPTH.
REQ-017 Port done SHALL be an output, 1 bit: countdown reached zero.
REQ-018 Port wrap SHALL be an output, 1 bit: one-cycle pulse on up-count rollover.

Function
REQ-019 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE.
REQ-020 The FSM transitions SHALL be: IDLE -start_stop-> RUN; RUN -start_stop-> PAUSE; PAUSE -start_stop-> RUN; RUN -zero reached in down mode-> DONE; any state -clear-> IDLE.
REQ-021 When clear and start_stop occur in the same cycle, clear SHALL win.
REQ-022 When start_stop occurs in DONE without clear, it SHALL be ignored.
REQ-023 The prescaler SHALL count 0..CLK_DIV-1 only in RUN, hold its value in PAUSE, and zero on entry to RUN from IDLE.
REQ-024 The tick SHALL occur in the cycle the prescaler equals CLK_DIV-1, and the time SHALL update on the following clock edge.
REQ-025 The BCD time SHALL be held as digits with limits cc 00-99, ss 00-59 and mm 00-59, and no digit SHALL ever hold an illegal BCD value.
REQ-026 In up mode, a tick at 59:59.99 SHALL roll the time to 00:00.00 and pulse wrap for 1 cycle.
REQ-027 In down mode, the time SHALL load from preset on IDLE->RUN and decrement with borrow across digits.
REQ-028 In down mode, the tick that produces 00:00.00 SHALL enter DONE, and done SHALL stay high until clear.
REQ-029 In down mode, a preset of 00:00.00 SHALL enter DONE on the first tick.
REQ-030 The lap input SHALL be honoured only in RUN or PAUSE, writing the current time to entry lap_count and incrementing lap_count.
REQ-031 A lap pulse when lap_full is high SHALL be dropped, with no overwrite and no change to lap_count.
REQ-032 A lap pulse coincident with a tick SHALL capture the pre-tick time.
REQ-033 A lap pulse coincident with clear SHALL be ignored.
REQ-034 disp_bcd SHALL be combinational from registers, showing lap entry lap_sel when view_lap=1 and lap_sel<lap_count, and the live time otherwise.
REQ-035 clear SHALL zero the time, prescaler and lap_count, and lap-memory contents SHALL be don't-care once lap_count is zero.

Reset
REQ-036 When reset_n is low, the block SHALL asynchronously force state=IDLE, time=0, prescaler=0 and lap_count=0.
REQ-037 Reset SHALL drive the outputs to disp_bcd=24'h000000, running=0, lap_full=0, done=0 and wrap=0.
REQ-038 Reset asserted mid-run SHALL abandon the count with no further output pulses.
REQ-039 Reset release SHALL be synchronised externally, and the block SHALL resume in IDLE.

Configuration
REQ-040 Macro LAP_STOPWATCH_COUNTDOWN_EN SHALL select the countdown feature.
REQ-041 When LAP_STOPWATCH_COUNTDOWN_EN is defined, down mode, preset loading and the DONE state SHALL be present.
REQ-042 When LAP_STOPWATCH_COUNTDOWN_EN is undefined, mode and preset SHALL be ignored, counting SHALL be up only, DONE SHALL be unreachable, and done SHALL be tied to 0.

Structure
REQ-043 Package stopwatch_pkg SHALL hold the state enum, the bcd_time_t struct (mm, ss and cc digit pairs) and the digit-limit constants.
REQ-044 Sub-module bcd_time_counter SHALL implement the BCD increment/decrement with wrap/zero flags, and the FSM, prescaler and lap memory SHALL remain in lap_stopwatch.

Verification (CLK_DIV=2, LAP_DEPTH=4)
REQ-045 Scenario 1: reset, start, 250 ticks -> disp_bcd=00:02.50 and running=1.
REQ-046 Scenario 2: start, pause for 10 ticks' worth of cycles, then resume -> time frozen during pause and the count continues from the held prescaler phase.
REQ-047 Scenario 3: with up mode and time forced via run to 59:59.99, apply 1 tick -> 00:00.00 and wrap pulses once.
REQ-048 Scenario 4: with preset 00:00.03 in down mode, start and run 3 ticks -> DONE, done=1, and the time holds 00:00.00.
REQ-049 Scenario 5: apply 5 lap pulses at distinct times -> lap_count=4, lap_full=1, the 5th is dropped, and view_lap with lap_sel=0..3 returns the first four times.
REQ-050 Scenario 6: clear+start_stop in the same cycle and reset_n low mid-RUN -> both end in IDLE with all outputs at reset values.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and BCD digit-pair helpers for the lap stopwatch.
// State encoding, the mm:ss:cc time struct and the per-field digit limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_t;

  typedef struct packed {
    logic [7:0] mm;
    logic [7:0] ss;
    logic [7:0] cc;
  } bcd_time_t;

  localparam logic [7:0] CC_MAX = 8'h99;
  localparam logic [7:0] SS_MAX = 8'h59;
  localparam logic [7:0] MM_MAX = 8'h59;
  localparam bcd_time_t  TIME_ZERO = '0;

  // Returns {carry, next_pair}; carry is set when the pair rolls from max to 00.
  function automatic logic [8:0] pair_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)              return {1'b1, 8'h00};
    else if (v[3:0] == 4'd9)   return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                       return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // Returns {borrow, next_pair}; borrow is set when the pair wraps from 00 to max.
  function automatic logic [8:0] pair_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)            return {1'b1, max};
    else if (v[3:0] == 4'd0)   return {1'b0, v[7:4] - 4'd1, 4'd9};
    else                       return {1'b0, v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Combinational next-time logic for the mm:ss:cc BCD counter.
// Up mode reports a 59:59.99 -> 00:00.00 rollover; down mode saturates at zero and flags it.
module bcd_time_counter
  import stopwatch_pkg::*;
(
  input  bcd_time_t i_time,
  input  logic      i_down,
  output bcd_time_t o_next,
  output logic      o_wrap,
  output logic      o_zero
);

  logic [8:0] w_cc_inc, w_ss_inc, w_mm_inc;
  logic [8:0] w_cc_dec, w_ss_dec, w_mm_dec;
  bcd_time_t  w_dec;
  logic       w_underflow;

  always_comb begin
    w_cc_inc = pair_inc(i_time.cc, CC_MAX);
    w_ss_inc = pair_inc(i_time.ss, SS_MAX);
    w_mm_inc = pair_inc(i_time.mm, MM_MAX);
    w_cc_dec = pair_dec(i_time.cc, CC_MAX);
    w_ss_dec = pair_dec(i_time.ss, SS_MAX);
    w_mm_dec = pair_dec(i_time.mm, MM_MAX);

    w_dec.cc = w_cc_dec[7:0];
    w_dec.ss = w_cc_dec[8] ? w_ss_dec[7:0] : i_time.ss;
    w_dec.mm = (w_cc_dec[8] && w_ss_dec[8]) ? w_mm_dec[7:0] : i_time.mm;
    // Every pair borrowing at once only happens from 00:00.00.
    w_underflow = w_cc_dec[8] && w_ss_dec[8] && w_mm_dec[8];

    o_next = i_time;
    o_wrap = 1'b0;
    o_zero = 1'b0;
    if (i_down) begin
      o_next = w_underflow ? TIME_ZERO : w_dec;
      o_zero = w_underflow || (w_dec == TIME_ZERO);
    end else begin
      o_next.cc = w_cc_inc[7:0];
      o_next.ss = w_cc_inc[8] ? w_ss_inc[7:0] : i_time.ss;
      o_next.mm = (w_cc_inc[8] && w_ss_inc[8]) ? w_mm_inc[7:0] : i_time.mm;
      o_wrap    = w_cc_inc[8] && w_ss_inc[8] && w_mm_inc[8];
    end
  end

endmodule

// File: rtl/lap_stopwatch.sv
// Centisecond BCD stopwatch with run/pause FSM, prescaler and a small lap memory.
// Countdown (down mode, preset load, DONE state) is built only with LAP_STOPWATCH_COUNTDOWN_EN.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter  int CLK_DIV   = 500000,
  parameter  int LAP_DEPTH = 4,
  localparam int SEL_W     = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
  localparam int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             mode,
  input  logic [23:0]      preset,
  input  logic [SEL_W-1:0] lap_sel,
  input  logic             view_lap,
  output logic [23:0]      disp_bcd,
  output logic             running,
  output logic [CNT_W-1:0] lap_count,
  output logic             lap_full,
  output logic             done,
  output logic             wrap,
  output logic [1:0]       dbg_state
);

  localparam int PRE_W = $clog2(CLK_DIV);

  sw_state_t        r_state;
  bcd_time_t        r_time;
  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_lap_count;
  logic             r_wrap;
  bcd_time_t        r_laps [LAP_DEPTH];

  bcd_time_t w_next, w_load_time;
  logic      w_tick, w_wrap, w_zero, w_down, w_lap_wr, w_lap_view;

`ifdef LAP_STOPWATCH_COUNTDOWN_EN
  logic r_mode_down;

  // Direction is frozen once the watch leaves IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                r_mode_down <= 1'b0;
    else if (r_state == ST_IDLE) r_mode_down <= mode;
  end

  assign w_down      = r_mode_down;
  assign w_load_time = mode ? bcd_time_t'(preset) : TIME_ZERO;
  assign done        = (r_state == ST_DONE);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{mode, preset};
  assign w_down       = 1'b0;
  assign w_load_time  = TIME_ZERO;
  assign done         = 1'b0;
`endif

  bcd_time_counter u_counter (
    .i_time (r_time),
    .i_down (w_down),
    .o_next (w_next),
    .o_wrap (w_wrap),
    .o_zero (w_zero)
  );

  assign w_tick   = (r_state == ST_RUN) && (r_pre == PRE_W'(CLK_DIV - 1));
  assign w_lap_wr = lap && !clear && !lap_full &&
                    ((r_state == ST_RUN) || (r_state == ST_PAUSE));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_time      <= TIME_ZERO;
      r_pre       <= '0;
      r_lap_count <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clear) begin
        r_state     <= ST_IDLE;
        r_time      <= TIME_ZERO;
        r_pre       <= '0;
        r_lap_count <= '0;
      end else begin
        if (w_lap_wr) r_lap_count <= r_lap_count + 1'b1;
        case (r_state)
          ST_IDLE: begin
            if (start_stop) begin
              r_state <= ST_RUN;
              r_time  <= w_load_time;
              r_pre   <= '0;
            end
          end
          ST_RUN: begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
              r_time <= w_next;
              r_wrap <= w_wrap;
            end
            // Reaching zero outranks a simultaneous pause request.
            if (w_tick && w_zero) r_state <= ST_DONE;
            else if (start_stop)  r_state <= ST_PAUSE;
          end
          ST_PAUSE: begin
            if (start_stop) r_state <= ST_RUN;
          end
          default: ;
        endcase
      end
    end
  end

  // Lap entries are only meaningful below lap_count, so they need no reset.
  always_ff @(posedge clock) begin
    if (w_lap_wr) r_laps[r_lap_count[SEL_W-1:0]] <= r_time;
  end

  assign w_lap_view = view_lap && (CNT_W'(lap_sel) < r_lap_count);
  assign disp_bcd   = w_lap_view ? r_laps[lap_sel] : r_time;
  assign running    = (r_state == ST_RUN);
  assign lap_count  = r_lap_count;
  assign lap_full   = (r_lap_count == CNT_W'(LAP_DEPTH));
  assign wrap       = r_wrap;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch (CLK_DIV=2, LAP_DEPTH=4): the driver pushes
// hand-computed expectations into exp_q and a negedge monitor pops and compares them.
module tb_lap_stopwatch;

  localparam int CLK_DIV   = 2;
  localparam int LAP_DEPTH = 4;

  localparam int K_DISP  = 0;
  localparam int K_RUN   = 1;
  localparam int K_CNT   = 2;
  localparam int K_FULL  = 3;
  localparam int K_DONE  = 4;
  localparam int K_WRAP  = 5;
  localparam int K_STATE = 6;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear      = 1'b0;
  logic        lap        = 1'b0;
  logic        mode       = 1'b0;
  logic [23:0] preset     = 24'h0;
  logic [1:0]  lap_sel    = 2'd0;
  logic        view_lap   = 1'b0;

  logic [23:0] disp_bcd;
  logic        running;
  logic [2:0]  lap_count;
  logic        lap_full;
  logic        done;
  logic        wrap;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        chk_req  = 1'b0;

  lap_stopwatch #(.CLK_DIV(CLK_DIV), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .mode       (mode),
    .preset     (preset),
    .lap_sel    (lap_sel),
    .view_lap   (view_lap),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .lap_count  (lap_count),
    .lap_full   (lap_full),
    .done       (done),
    .wrap       (wrap),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running sim, required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [23:0] actual(input int k);
    case (k)
      K_DISP:  return disp_bcd;
      K_RUN:   return {23'd0, running};
      K_CNT:   return {21'd0, lap_count};
      K_FULL:  return {23'd0, lap_full};
      K_DONE:  return {23'd0, done};
      K_WRAP:  return {23'd0, wrap};
      default: return {22'd0, dbg_state};
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_DISP:  return "disp_bcd";
      K_RUN:   return "running";
      K_CNT:   return "lap_count";
      K_FULL:  return "lap_full";
      K_DONE:  return "done";
      K_WRAP:  return "wrap";
      default: return "state";
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clock) begin
    if (chk_req) begin
      while (exp_q.size() > 0) begin
        logic [31:0] e;
        logic [23:0] a;
        e = exp_q.pop_front();
        a = actual(int'(e[31:24]));
        n_checks++;
        if (a !== e[23:0]) begin
          n_errors++;
          $display("FAIL %s check#%0d at %0t: got %h required %h",
                   kname(int'(e[31:24])), n_checks, $time, a, e[23:0]);
        end
      end
      chk_req = 1'b0;
    end
  end

  // driver tasks
  task automatic expect_val(input int k, input logic [23:0] v);
    exp_q.push_back({8'(k), v});
  endtask

  task automatic check_now();
    chk_req = 1'b1;
    @(negedge clock);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start_stop = 1'b1; step(1); start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; step(1); lap = 1'b0;
  endtask

  task automatic pulse_clear_start();
    clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0; start_stop = 1'b0;
  endtask

  task automatic expect_idle();
    expect_val(K_DISP, 24'h000000);
    expect_val(K_RUN, 24'd0);
    expect_val(K_CNT, 24'd0);
    expect_val(K_FULL, 24'd0);
    expect_val(K_DONE, 24'd0);
    expect_val(K_WRAP, 24'd0);
    expect_val(K_STATE, 24'd0);
  endtask

  initial begin
    logic [23:0] exp_laps [4];
    exp_laps[0] = 24'h000001;
    exp_laps[1] = 24'h000002;
    exp_laps[2] = 24'h000004;
    exp_laps[3] = 24'h000005;

    // reset values
    #12;
    expect_idle();
    check_now();
    step(2);
    reset_n = 1'b1;
    step(1);

    // 250 ticks at two cycles per tick
    pulse_start();
    step(500);
    expect_val(K_DISP, 24'h000250);
    expect_val(K_RUN, 24'd1);
    expect_val(K_STATE, 24'd1);
    check_now();

    // pause with the prescaler mid-phase, then resume one cycle before the tick
    pulse_start();
    step(20);
    expect_val(K_DISP, 24'h000250);
    expect_val(K_RUN, 24'd0);
    expect_val(K_STATE, 24'd2);
    check_now();
    pulse_start();
    step(1);
    expect_val(K_DISP, 24'h000251);
    expect_val(K_RUN, 24'd1);
    check_now();
    step(1);
    expect_val(K_DISP, 24'h000251);
    check_now();
    step(1);
    expect_val(K_DISP, 24'h000252);
    check_now();

    // clear, lap ignored in IDLE, rollover from 59:59.99
    pulse_clear();
    expect_idle();
    check_now();
    pulse_lap();
    expect_val(K_CNT, 24'd0);
    check_now();
    force dut.w_load_time = 24'h595999;
    pulse_start();
    release dut.w_load_time;
    expect_val(K_DISP, 24'h595999);
    expect_val(K_RUN, 24'd1);
    check_now();
    step(2);
    expect_val(K_DISP, 24'h000000);
    expect_val(K_WRAP, 24'd1);
    check_now();
    step(1);
    expect_val(K_DISP, 24'h000000);
    expect_val(K_WRAP, 24'd0);
    check_now();
    step(1);
    expect_val(K_DISP, 24'h000001);
    expect_val(K_WRAP, 24'd0);
    check_now();

    // laps: off-tick, on-tick (pre-tick time), on-tick, in PAUSE, then dropped
    pulse_lap();
    expect_val(K_CNT, 24'd1);
    expect_val(K_FULL, 24'd0);
    check_now();
    step(2);
    pulse_lap();
    step(3);
    pulse_lap();
    pulse_start();
    pulse_lap();
    expect_val(K_CNT, 24'd4);
    expect_val(K_FULL, 24'd1);
    check_now();
    pulse_lap();
    expect_val(K_CNT, 24'd4);
    expect_val(K_FULL, 24'd1);
    expect_val(K_DISP, 24'h000005);
    expect_val(K_STATE, 24'd2);
    check_now();
    view_lap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lap_sel = 2'(i);
      #1;
      expect_val(K_DISP, exp_laps[i]);
      check_now();
    end
    view_lap = 1'b0;
    lap_sel  = 2'd0;

    // clear beats start_stop; stale lap memory is not shown
    pulse_clear_start();
    expect_idle();
    check_now();
    view_lap = 1'b1;
    #1;
    expect_val(K_DISP, 24'h000000);
    check_now();
    view_lap = 1'b0;

    // asynchronous reset mid-run
    pulse_start();
    step(4);
    expect_val(K_DISP, 24'h000002);
    expect_val(K_RUN, 24'd1);
    check_now();
    step(1);
    #2;
    reset_n = 1'b0;
    expect_idle();
    check_now();
    step(3);
    expect_idle();
    check_now();
    reset_n = 1'b1;
    step(4);
    expect_idle();
    check_now();

`ifdef LAP_STOPWATCH_COUNTDOWN_EN
    // countdown from 00:00.03 and from a zero preset
    mode   = 1'b1;
    preset = 24'h000003;
    step(1);
    pulse_start();
    step(6);
    expect_val(K_DISP, 24'h000000);
    expect_val(K_DONE, 24'd1);
    expect_val(K_RUN, 24'd0);
    expect_val(K_STATE, 24'd3);
    check_now();
    step(4);
    expect_val(K_DISP, 24'h000000);
    expect_val(K_DONE, 24'd1);
    check_now();
    pulse_start();
    expect_val(K_STATE, 24'd3);
    expect_val(K_DONE, 24'd1);
    check_now();
    pulse_clear();
    expect_idle();
    check_now();
    preset = 24'h000000;
    pulse_start();
    step(2);
    expect_val(K_DISP, 24'h000000);
    expect_val(K_DONE, 24'd1);
    expect_val(K_STATE, 24'd3);
    check_now();
    pulse_clear();
`else
    // mode and preset have no effect without the countdown feature
    mode   = 1'b1;
    preset = 24'h000003;
    step(1);
    pulse_start();
    step(6);
    expect_val(K_DISP, 24'h000003);
    expect_val(K_DONE, 24'd0);
    expect_val(K_RUN, 24'd1);
    expect_val(K_STATE, 24'd1);
    check_now();
    pulse_clear();
`endif

    step(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
